// File: rtl/des_pkg.sv
// Shared definitions for the DES block-mode sequencer: block type, FSM encoding,
// chaining mode constants and known-answer vectors for the standard test key.
package des_pkg;

    localparam int DES_BLK_W = 64;

    typedef logic [0:DES_BLK_W-1] blk_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    localparam blk_t KAT_KEY = 64'h133457799BBCDFF1;
    localparam blk_t KAT_PT  = 64'h0123456789ABCDEF;
    localparam blk_t KAT_CT  = 64'h85E813540F0AB405;

    function automatic blk_t blk_xor(input blk_t a, input blk_t b);
        return a ^ b;
    endfunction

    // Only CBC encryption whitens the block before the core; CBC decryption
    // applies the chain value after the core instead.
    function automatic blk_t chain_in(input blk_t data, input blk_t chain,
                                      input logic cbc, input logic decrypt);
        if (cbc == MODE_CBC && !decrypt) begin
            return blk_xor(data, chain);
        end
        return data;
    endfunction

endpackage

// File: rtl/des_mode_ctrl.sv
// ECB/CBC block-mode sequencer sitting in front of an iterative DES core:
// accepts a block, holds the core inputs for DES_LATENCY edges, returns the result.
module des_mode_ctrl
    import des_pkg::*;
#(
    parameter int DES_LATENCY = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic [0:63]          cfg_key,
    input  logic [0:63]          cfg_iv,
    input  logic                 cfg_decrypt,
    input  logic                 cfg_cbc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:63]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:63]          out_data,
    output logic [0:63]          core_in,
    output logic [0:63]          core_key,
    output logic                 core_decrypt,
    input  logic [0:63]          core_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_count
);

    localparam int LAT_W = (DES_LATENCY < 2) ? 1 : $clog2(DES_LATENCY + 1);

    state_t           state_q,    state_d;
    blk_t             key_q,      key_d;
    logic             dec_q,      dec_d;
    logic             cbc_q,      cbc_d;
    blk_t             chain_q,    chain_d;
    blk_t             hold_q,     hold_d;
    blk_t             core_in_q,  core_in_d;
    blk_t             out_data_q, out_data_d;
    logic [LAT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] blk_cnt_q,  blk_cnt_d;

    // Config that applies to a block accepted on the same edge as cfg_load.
    logic             eff_dec;
    logic             eff_cbc;
    blk_t             eff_chain;

    always_comb begin
        eff_dec   = cfg_load ? cfg_decrypt : dec_q;
        eff_cbc   = cfg_load ? cfg_cbc     : cbc_q;
        eff_chain = cfg_load ? cfg_iv      : chain_q;
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        dec_d      = dec_q;
        cbc_d      = cbc_q;
        chain_d    = chain_q;
        hold_d     = hold_q;
        core_in_d  = core_in_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        blk_cnt_d  = blk_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    key_d   = cfg_key;
                    dec_d   = cfg_decrypt;
                    cbc_d   = cfg_cbc;
                    chain_d = cfg_iv;
                end
                if (in_valid) begin
                    core_in_d = chain_in(in_data, eff_chain, eff_cbc, eff_dec);
                    hold_d    = in_data;
                    cnt_d     = LAT_W'(DES_LATENCY);
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    out_data_d = core_out;
                    if (cbc_q == MODE_CBC) begin
                        if (dec_q) begin
                            out_data_d = blk_xor(core_out, chain_q);
                            chain_d    = hold_q;
                        end else begin
                            chain_d    = core_out;
                        end
                    end
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            dec_q      <= 1'b0;
            cbc_q      <= MODE_ECB;
            chain_q    <= '0;
            hold_q     <= '0;
            core_in_q  <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            dec_q      <= dec_d;
            cbc_q      <= cbc_d;
            chain_q    <= chain_d;
            hold_q     <= hold_d;
            core_in_q  <= core_in_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign out_data     = out_data_q;
    assign core_in      = core_in_q;
    assign core_key     = key_q;
    assign core_decrypt = dec_q;
    assign blk_count    = blk_cnt_q;

endmodule

// File: doc/des_mode_ctrl.md
Name: des_mode_ctrl

Overview:
Block-mode sequencer for the iterative DES core (`des`, 64-bit block, 64-bit key, decrypt select, `clk`).
- Accepts 64-bit blocks on a valid/ready stream.
- Applies ECB or CBC chaining, drives the core and holds its inputs stable for the core latency.
- Captures the result and presents it on a valid/ready output stream.
- Sits between the host/bus logic and the `des` instance, which is instantiated alongside it by the parent.

Parameters:
- DES_LATENCY, 16, clock edges from stable core inputs to valid `core_out`; minimum 1.
- CNT_W, 16, width of the processed-block counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_load  in  1  pulse: latch cfg_key/cfg_iv/cfg_decrypt/cfg_cbc; honoured only in IDLE
- cfg_key  in  [0:63]  DES key, bit 0 = MSB
- cfg_iv  in  [0:63]  CBC initial vector
- cfg_decrypt  in  1  1 = decrypt
- cfg_cbc  in  1  1 = CBC, 0 = ECB
- in_valid  in  1  input block valid
- in_ready  out  1  controller can accept a block
- in_data  in  [0:63]  plaintext (encrypt) or ciphertext (decrypt)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  [0:63]  result block
- core_in  out  [0:63]  to des desIn
- core_key  out  [0:63]  to des key
- core_decrypt  out  1  to des decrypt
- core_out  in  [0:63]  from des desOut
- busy  out  1  high in RUN or DONE
- blk_count  out  CNT_W  blocks delivered since reset, wraps at 2^CNT_W

Behaviour:
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; core_in=0; core_key=0; core_decrypt=0; busy=0; blk_count=0; latched key/iv/mode=0 (ECB encrypt); chain register=0.
- Reset is asynchronous at any time, including mid-RUN. It abandons the block in flight; no output is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - cfg_load=1 latches the config and loads chain <= cfg_iv.
  - If cfg_load and in_valid are high on the same edge, cfg_load applies first; the block then uses the new config and the new IV.
  - On accept (in_valid & in_ready):
    - ECB or CBC-decrypt: core_in <= in_data.
    - CBC-encrypt: core_in <= in_data ^ chain.
    - Save in_data in a hold register; load counter <= DES_LATENCY; go to RUN.
- RUN:
  - in_ready=0; core_in, core_key and core_decrypt are held constant.
  - Counter decrements each edge. On the edge where the counter is 1, sample core_out. With the accept edge counted as edge 0, the sample is taken at edge DES_LATENCY.
  - out_data at that edge:
    - ECB: core_out.
    - CBC-encrypt: core_out; chain <= core_out.
    - CBC-decrypt: core_out ^ chain; chain <= hold (the ciphertext).
  - Set out_valid=1; go to DONE.
- DONE:
  - out_valid=1; out_data stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0; blk_count++; go to IDLE.
  - The next block can be accepted one cycle after the handshake.
- cfg_load outside IDLE is ignored entirely; config and chain are unchanged.
- core_key and core_decrypt mirror the latched config registers.
- Chain state persists across blocks until the next cfg_load or reset.
- Mode switch mid-stream is possible only via cfg_load, which also reloads the IV.
- in_data is ignored unless accepted.
- blk_count wraps from 2^CNT_W-1 to 0.
- Throughput: one block per DES_LATENCY+2 cycles when out_ready is tied high.

Decomposition:
- Shared package des_pkg:
  - DES_BLK_W=64.
  - State encoding localparams ST_IDLE/ST_RUN/ST_DONE.
  - Mode constants MODE_ECB=0, MODE_CBC=1.
  - Known-answer constants for benches.
- No sub-module is needed; the latency counter and chain register stay inline.
- The `des` core is instantiated by the parent, not inside this block.

Test Plan:
- ECB encrypt: cfg key=133457799BBCDFF1, ECB, enc; send 0123456789ABCDEF -> out_data=85E813540F0AB405, out_valid exactly DES_LATENCY edges after accept, blk_count=1.
- ECB decrypt: same key, decrypt; send 85E813540F0AB405 -> 0123456789ABCDEF.
- CBC round trip:
  - Encrypt: IV=0000000000000000, CBC; send 0123456789ABCDEF twice -> first 85E813540F0AB405, second = DES(0123456789ABCDEF ^ 85E813540F0AB405).
  - Decrypt: reload IV=0, decrypt; feed both ciphertexts -> 0123456789ABCDEF twice.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, no blk_count change; release -> single handshake, in_ready high the next cycle.
- Ignored config: pulse cfg_load with a different key during RUN -> current and next block still use the old key.
- Reset mid-run: assert rst_n=0 at RUN cycle 5 -> all outputs at reset values immediately; no out_valid after release; the next block uses ECB encrypt with key 0.
